// File: rtl/serial_port_responder_if.sv
// Memory-controller side of the serial port: strobes, data bus and status flags.
interface serial_port_responder_if;
  logic [7:0] busDataIn;
  logic [7:0] busDataOut;
  logic       busDataOE;
  logic       rdn;
  logic       wrn;
  logic       tbre;
  logic       tsre;
  logic       data_ready;

  modport master (output busDataIn, rdn, wrn,
                  input  busDataOut, busDataOE, tbre, tsre, data_ready);
  modport slave  (input  busDataIn, rdn, wrn,
                  output busDataOut, busDataOE, tbre, tsre, data_ready);
endinterface

// File: rtl/serial_port_responder.sv
// Strobe-driven UART responder: 8N1 transmitter fed by a one-byte THR and an
// oversampling receiver feeding a one-byte RBR, with independent TX/RX FSMs.
module serial_port_responder #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  serial_port_responder_if.slave  bus,
  output logic                    txd,
  input  logic                    rxd,
  output logic                    frameErr,
  output logic                    overrun
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3;
  localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;

  logic rdn_r, rdn_d, wrn_r, wrn_d;
  logic rd_fall, wr_fall;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdn_r <= 1'b1; rdn_d <= 1'b1;
      wrn_r <= 1'b1; wrn_d <= 1'b1;
    end else begin
      rdn_r <= bus.rdn; rdn_d <= rdn_r;
      wrn_r <= bus.wrn; wrn_d <= wrn_r;
    end
  end

  // A write overlapping an active read is ignored.
  assign rd_fall = rdn_d & ~rdn_r;
  assign wr_fall = wrn_d & ~wrn_r & rdn_r;

  logic [7:0] rbr;
  logic       dr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.busDataOE  <= 1'b0;
      bus.busDataOut <= 8'h00;
    end else begin
      bus.busDataOE  <= ~rdn_r;
      bus.busDataOut <= rdn_r ? 8'h00 : rbr;
    end
  end

  // ---------------- transmitter ----------------
  logic [1:0]    tx_state;
  logic [BW-1:0] tx_baud;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh, thr;
  logic          tbre_r, tsre_r, tx_last;

  assign tx_last = (tx_baud == BAUD_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state <= TX_IDLE; tx_baud <= '0; tx_bit <= '0;
      tx_sh <= '0; thr <= '0;
      tbre_r <= 1'b1; tsre_r <= 1'b1; txd <= 1'b1;
    end else begin
      if (wr_fall && tbre_r) begin
        thr    <= bus.busDataIn;
        tbre_r <= 1'b0;
      end
      case (tx_state)
        TX_IDLE: if (!tbre_r) begin
          tx_sh <= thr; tbre_r <= 1'b1; tsre_r <= 1'b0;
          txd <= 1'b0; tx_baud <= '0; tx_state <= TX_START;
        end
        TX_START: if (tx_last) begin
          tx_baud <= '0; txd <= tx_sh[0]; tx_sh <= tx_sh >> 1;
          tx_bit <= '0; tx_state <= TX_DATA;
        end else tx_baud <= tx_baud + 1'b1;
        TX_DATA: if (tx_last) begin
          tx_baud <= '0;
          if (tx_bit == 3'd7) begin
            txd <= 1'b1; tx_state <= TX_STOP;
          end else begin
            txd <= tx_sh[0]; tx_sh <= tx_sh >> 1; tx_bit <= tx_bit + 3'd1;
          end
        end else tx_baud <= tx_baud + 1'b1;
        TX_STOP: if (tx_last) begin
          tx_baud <= '0;
          // A pending byte starts immediately: no idle bit between frames.
          if (!tbre_r) begin
            tx_sh <= thr; tbre_r <= 1'b1; txd <= 1'b0; tx_state <= TX_START;
          end else begin
            tsre_r <= 1'b1; tx_state <= TX_IDLE;
          end
        end else tx_baud <= tx_baud + 1'b1;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign bus.tbre = tbre_r;
  assign bus.tsre = tsre_r;

  // ---------------- receiver ----------------
  logic          rx_s1, rx_s2;
  logic [1:0]    rx_state;
  logic [BW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1;
      rx_state <= RX_IDLE; rx_cnt <= '0; rx_bit <= '0; rx_sh <= '0;
      rbr <= '0; dr <= 1'b0; frameErr <= 1'b0; overrun <= 1'b0;
    end else begin
      rx_s1 <= rxd; rx_s2 <= rx_s1;
      frameErr <= 1'b0;
      overrun  <= 1'b0;
      if (rd_fall) dr <= 1'b0;
      case (rx_state)
        RX_IDLE: if (!rx_s2) begin
          rx_cnt <= '0; rx_state <= RX_START;
        end
        RX_START: if (rx_cnt == HALF_LAST) begin
          rx_cnt <= '0; rx_bit <= '0;
          rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_DATA: if (rx_cnt == BAUD_LAST) begin
          rx_cnt <= '0; rx_sh <= {rx_s2, rx_sh[7:1]};
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
          else rx_bit <= rx_bit + 3'd1;
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_STOP: if (rx_cnt == BAUD_LAST) begin
          rx_cnt <= '0; rx_state <= RX_IDLE;
          // Completion overrides a simultaneous read clear and is not an overrun.
          if (rx_s2) begin
            rbr <= rx_sh; dr <= 1'b1; overrun <= dr & ~rd_fall;
          end else frameErr <= 1'b1;
        end else rx_cnt <= rx_cnt + 1'b1;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign bus.data_ready = dr;
endmodule

// File: tb/tb_serial_port_responder.sv
// Directed bench for serial_port_responder at 16 clocks per bit.
module tb_serial_port_responder;
  logic CLK = 1'b0;
  logic RST;
  logic txd, rxd, frameErr, overrun;
  int   checks = 0, failures = 0;
  int   fe_cnt = 0, ov_cnt = 0;
  logic [7:0] d;

  serial_port_responder_if bus();

  serial_port_responder #(.CLKS_PER_BIT(16)) dut (
    .CLK(CLK), .RST(RST), .bus(bus),
    .txd(txd), .rxd(rxd), .frameErr(frameErr), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (frameErr === 1'b1) fe_cnt++;
    if (overrun  === 1'b1) ov_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] v);
    @(negedge CLK); bus.busDataIn = v; bus.wrn = 1'b0;
    @(negedge CLK); bus.wrn = 1'b1;
  endtask

  task automatic do_read(input string tag, input logic [7:0] v);
    @(negedge CLK); bus.rdn = 1'b0;
    tick(2);
    chk({tag, "_oe"}, bus.busDataOE, 8'd1);
    chk({tag, "_data"}, bus.busDataOut, v);
    chk({tag, "_dr_clr"}, bus.data_ready, 8'd0);
    bus.rdn = 1'b1;
    tick(3);
    chk({tag, "_oe_off"}, bus.busDataOE, 8'd0);
  endtask

  task automatic send_frame(input logic [7:0] v, input logic stop);
    @(negedge CLK); rxd = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rxd = v[i]; tick(16);
    end
    rxd = stop; tick(16);
    rxd = 1'b1;
  endtask

  initial begin
    RST = 1'b1; rxd = 1'b1;
    bus.rdn = 1'b1; bus.wrn = 1'b1; bus.busDataIn = 8'h00;
    tick(3);
    chk("rst_txd", txd, 8'd1);
    chk("rst_tbre", bus.tbre, 8'd1);
    chk("rst_tsre", bus.tsre, 8'd1);
    chk("rst_dr", bus.data_ready, 8'd0);
    chk("rst_oe", bus.busDataOE, 8'd0);
    chk("rst_out", bus.busDataOut, 8'h00);
    chk("rst_fe", frameErr, 8'd0);
    chk("rst_ov", overrun, 8'd0);
    RST = 1'b0;
    tick(3);

    // Reset in the middle of a frame, while txd is driving a 0 data bit.
    do_write(8'h55);
    tick(40);
    chk("pre_rst_txd", txd, 8'd0);
    RST = 1'b1;
    tick(1);
    chk("midrst_txd", txd, 8'd1);
    chk("midrst_tbre", bus.tbre, 8'd1);
    chk("midrst_tsre", bus.tsre, 8'd1);
    chk("midrst_dr", bus.data_ready, 8'd0);
    chk("midrst_oe", bus.busDataOE, 8'd0);
    tick(1);
    RST = 1'b0;
    tick(5);

    // Single byte 0x55.
    d = 8'h55;
    do_write(d);
    tick(1);
    chk("tx1_tbre_lo", bus.tbre, 8'd0);
    tick(1);
    chk("tx1_tbre_hi", bus.tbre, 8'd1);
    chk("tx1_tsre_lo", bus.tsre, 8'd0);
    tick(8);
    chk("tx1_start", txd, 8'd0);
    for (int i = 0; i < 8; i++) begin
      tick(16);
      chk($sformatf("tx1_bit%0d", i), txd, {7'd0, d[i]});
    end
    tick(16);
    chk("tx1_stop", txd, 8'd1);
    tick(7);
    chk("tx1_tsre_busy", bus.tsre, 8'd0);
    tick(1);
    chk("tx1_tsre_done", bus.tsre, 8'd1);
    tick(10);

    // Back-to-back 0x55 / 0xA3, third write dropped.
    do_write(8'h55);
    tick(2);
    chk("tx2_tbre_hi", bus.tbre, 8'd1);
    do_write(8'hA3);
    tick(1);
    chk("tx2_thr_full", bus.tbre, 8'd0);
    do_write(8'h77);
    tick(147);
    chk("tx2_stop1", txd, 8'd1);
    tick(8);
    chk("tx2_start2", txd, 8'd0);
    chk("tx2_reload_tbre", bus.tbre, 8'd1);
    chk("tx2_reload_tsre", bus.tsre, 8'd0);
    d = 8'hA3;
    tick(8);
    chk("tx2_start2_mid", txd, 8'd0);
    for (int i = 0; i < 8; i++) begin
      tick(16);
      chk($sformatf("tx2_bit%0d", i), txd, {7'd0, d[i]});
    end
    tick(16);
    chk("tx2_stop2", txd, 8'd1);
    tick(7);
    chk("tx2_tsre_busy", bus.tsre, 8'd0);
    tick(1);
    chk("tx2_tsre_done", bus.tsre, 8'd1);
    tick(40);
    chk("tx2_dropped_tsre", bus.tsre, 8'd1);
    chk("tx2_dropped_txd", txd, 8'd1);

    // Receive 0x3C and read it.
    send_frame(8'h3C, 1'b1);
    tick(4);
    chk("rx1_dr", bus.data_ready, 8'd1);
    chk("rx1_oe_idle", bus.busDataOE, 8'd0);
    do_read("rx1_rd", 8'h3C);

    // Glitch, then framing error.
    @(negedge CLK); rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(40);
    chk("glitch_dr", bus.data_ready, 8'd0);
    chk("glitch_fe", fe_cnt[7:0], 8'd0);
    send_frame(8'h81, 1'b0);
    tick(40);
    chk("fe_count", fe_cnt[7:0], 8'd1);
    chk("fe_dr", bus.data_ready, 8'd0);

    // Overrun on an unread byte.
    send_frame(8'h11, 1'b1);
    tick(4);
    chk("ov_first_dr", bus.data_ready, 8'd1);
    chk("ov_none_yet", ov_cnt[7:0], 8'd0);
    send_frame(8'h22, 1'b1);
    tick(4);
    chk("ov_count", ov_cnt[7:0], 8'd1);
    chk("ov_dr", bus.data_ready, 8'd1);
    do_read("ov_rd", 8'h22);
    chk("fe_final", fe_cnt[7:0], 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
